// File: rtl/cpu_pkg.sv
// Shared front-end definitions: fetch state encoding, RV32 opcodes,
// immediate-type codes and the fetch buffer entry layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [2:0] imm_sel_of(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR: imm_sel_of = IMM_I;
      OP_STORE:                    imm_sel_of = IMM_S;
      OP_BRANCH:                   imm_sel_of = IMM_B;
      OP_LUI, OP_AUIPC:            imm_sel_of = IMM_U;
      OP_JAL:                      imm_sel_of = IMM_J;
      default:                     imm_sel_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, insn} FIFO between fetch and decode. Push and pop may
// coincide even when full; the head reads as zero while empty.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam logic [1:0] CAP = DEPTH[1:0];

  fetch_entry_t mem [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic         do_push, do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // when full, the slot being written is the one leaving this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with one outstanding request and a 2-entry output buffer.
// Optional: FETCH_PREDECODE_EN derives out_imm_sel from the head opcode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_sel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop, flush, accept;
  logic         buf_full, buf_empty;
  fetch_entry_t head;
  logic [1:0]   unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{pc: pc_q, insn: imem_rdata}),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    accept   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      // nothing is outstanding here, so a free slot is the only condition
      FETCH: begin
        imem_req = !buf_full;
        accept   = imem_req && imem_gnt;
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    // a response landing in the redirect cycle is dropped and closes the request
    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_d  = {redirect_pc[31:2], 2'b00};
      if (accept || ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid))
        state_d = DRAIN;
      else
        state_d = FETCH;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = !buf_empty;
  assign pop       = !buf_empty && out_ready;
  assign out_insn  = head.insn;
  assign out_pc    = head.pc;

`ifdef FETCH_PREDECODE_EN
  assign out_imm_sel = imm_sel_of(head.insn[6:0]);
`else
  assign out_imm_sel = IMM_NONE;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order stream model, latency-randomised memory,
// directed corner sequences and an opcode predecode table.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_insn, out_pc;
  logic [2:0]  out_imm_sel;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_pc         (out_pc),
    .out_imm_sel    (out_imm_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  sel;
  } vec_t;

  int total = 0, bad = 0, cyc = 0, pops = 0;
  int gnt_pct = 100, dly_min = 1, dly_max = 1;
  bit use_vec = 1'b0;
  logic [31:0] vec_insn [8];
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic [31:0] acc_log [$];
  logic [31:0] exp_pc;
  bit          prev_wait;
  logic [31:0] prev_addr;
  bit          rv_now, popped;
  logic [31:0] rv_addr_now, pop_pc;
  logic [2:0]  pop_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (use_vec) return vec_insn[a[4:2]];
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BD3;
  endfunction

  // One clock: drive inputs after negedge, sample, update the stream model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit ready);
    @(negedge clk);
    cyc++;
    redirect_valid = redir;
    redirect_pc    = tgt;
    out_ready      = ready;
    imem_gnt       = (int'($urandom_range(99)) < gnt_pct);
    rv_now         = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      rv_now      = 1'b1;
      rv_addr_now = pend_addr.pop_front();
      void'(pend_due.pop_front());
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(rv_addr_now);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (prev_wait) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
    if (imem_req && imem_gnt) begin
      chk("one_outstanding", 32'(pend_addr.size()), 32'd0);
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
      acc_log.push_back(imem_addr);
    end
    popped = out_valid && ready;
    if (popped) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_insn", out_insn, memfn(exp_pc));
      pop_pc  = out_pc;
      pop_sel = out_imm_sel;
      exp_pc  = exp_pc + 32'd4;
      pops++;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    prev_wait = imem_req && !imem_gnt && !redir;
    prev_addr = imem_addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    acc_log.delete();
    exp_pc    = 32'h0;
    prev_wait = 1'b0;
    rv_now    = 1'b0;
    popped    = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_insn", out_insn, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_sel", 32'(out_imm_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t        tbl [8];
  bit          had, got, r;
  logic [31:0] had_addr, first_pc, t;
  logic [2:0]  exp_sel;
  int          start_pops;

  initial begin
    tbl[0] = '{32'h0000_2083, 3'd1};
    tbl[1] = '{32'h00C5_8063, 3'd3};
    tbl[2] = '{32'h0011_2023, 3'd2};
    tbl[3] = '{32'h0000_10B7, 3'd4};
    tbl[4] = '{32'h0000_006F, 3'd5};
    tbl[5] = '{32'h0000_80E7, 3'd1};
    tbl[6] = '{32'h00B5_0533, 3'd0};
    tbl[7] = '{32'h0000_0097, 3'd4};
    for (int i = 0; i < 8; i++) vec_insn[i] = tbl[i].insn;

    // straight-line fetch, 1-cycle response, decode always ready
    do_reset();
    for (int i = 0; i < 10; i++) begin
      had      = rv_now;
      had_addr = rv_addr_now;
      step(1'b0, 32'h0, 1'b1);
      if (had) begin
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_pc", out_pc, had_addr);
      end
    end
    chk("seq_len", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      chk("seq0", acc_log[0], 32'h0);
      chk("seq1", acc_log[1], 32'h4);
      chk("seq2", acc_log[2], 32'h8);
    end

    // decode stalled: buffer fills to two and fetch stops
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b0);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_pc", out_pc, 32'h0);
    chk("full_accepts", 32'(acc_log.size()), 32'd2);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("full_second_valid", 32'(out_valid), 32'd1);
    chk("full_second_pc", out_pc, 32'h4);

    // redirect while a response is outstanding
    do_reset();
    dly_min = 3; dly_max = 3;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h103, 1'b1);
    acc_log.delete();
    got = 1'b0; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (popped) begin got = 1'b1; first_pc = pop_pc; end
    end
    chk("drain_popped", 32'(got), 32'd1);
    chk("drain_pc", first_pc, 32'h100);
    chk("drain_addr_cnt", 32'(acc_log.size() > 0), 32'd1);
    if (acc_log.size() > 0) chk("drain_addr", acc_log[0], 32'h100);

    // redirect coinciding with the response
    do_reset();
    dly_min = 1; dly_max = 1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    chk("same_rv", 32'(rv_now), 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("same_valid", 32'(out_valid), 32'd0);
    chk("same_req", 32'(imem_req), 32'd1);
    chk("same_addr", imem_addr, 32'h200);
    got = 1'b0; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (popped) begin got = 1'b1; first_pc = pop_pc; end
    end
    chk("same_popped", 32'(got), 32'd1);
    chk("same_pc", first_pc, 32'h200);

    // pc wrap at the top of the address space
    do_reset();
    gnt_pct = 0;
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    gnt_pct = 100;
    acc_log.delete();
    repeat (6) step(1'b0, 32'h0, 1'b1);
    chk("wrap_cnt", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      chk("wrap_a0", acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_a1", acc_log[1], 32'h0);
    end

    // opcode table through the whole pipe
    use_vec = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step(1'b0, 32'h0, 1'b1);
        got = popped;
      end
      chk("vec_popped", 32'(got), 32'd1);
      if (got) begin
`ifdef FETCH_PREDECODE_EN
        exp_sel = tbl[i].sel;
`else
        exp_sel = 3'd0;
`endif
        chk("vec_pc", pop_pc, 32'(i * 4));
        chk("vec_sel", 32'(pop_sel), 32'(exp_sel));
      end
    end
    use_vec = 1'b0;

    // random grant, latency, backpressure, redirects, one mid-run reset
    do_reset();
    gnt_pct = 60; dly_min = 1; dly_max = 3;
    start_pops = pops;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      r = (int'($urandom_range(99)) < 3);
      t = $urandom;
      step(r, t, int'($urandom_range(99)) < 70);
    end
    chk("rand_progress", 32'((pops - start_pops) > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
